// File: rtl/rv32_instr_encoder_pkg.sv
// Shared format codes, opcodes and FSM state type for the RV32I instruction encoder.
package rv32_instr_encoder_pkg;

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_J  = 3'd5;
  localparam logic [2:0] FMT_LI = 3'd6;

  localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
  localparam logic [6:0] OPCODE_ARITH_I = 7'b0010011;
  localparam logic [2:0] FUNCT3_ADDI    = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EMIT     = 2'd1,
    ST_EMIT_LUI = 2'd2
  } enc_state_t;

  // True when v fits a signed immediate of the given width (top bits all equal).
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned width);
    logic all_one;
    logic all_zero;
    all_one  = 1'b1;
    all_zero = 1'b1;
    for (int unsigned i = width - 1; i < 32; i++) begin
      all_one  = all_one & v[i];
      all_zero = all_zero & ~v[i];
    end
    return all_one | all_zero;
  endfunction

endpackage

// File: rtl/rv32_instr_encoder_imm_pack.sv
// Scatters a byte-offset/constant into the instruction-word immediate positions of each
// RV32I format and reports whether the value is representable.
module rv32_imm_pack
  import rv32_instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [31:0] imm_i,
  output logic [31:0] mask_o,
  output logic        range_ok_o
);

  always_comb begin
    mask_o     = '0;
    range_ok_o = 1'b0;
    case (fmt_i)
      FMT_R: begin
        range_ok_o = 1'b1;
      end
      FMT_I: begin
        mask_o     = {imm_i[11:0], 20'b0};
        range_ok_o = fits_signed(imm_i, 12);
      end
      FMT_S: begin
        mask_o     = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
        range_ok_o = fits_signed(imm_i, 12);
      end
      FMT_B: begin
        mask_o     = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
        range_ok_o = fits_signed(imm_i, 13) & ~imm_i[0];
      end
      FMT_U: begin
        mask_o     = {imm_i[31:12], 12'b0};
        range_ok_o = 1'b1;
      end
      FMT_J: begin
        mask_o     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
        range_ok_o = fits_signed(imm_i, 21) & ~imm_i[0];
      end
      FMT_LI: begin
        range_ok_o = 1'b1;
      end
      default: begin
        range_ok_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv32_instr_encoder.sv
// Streaming RV32I encoder: field-level requests in, sequentially addressed instruction
// words out; LI expands to LUI(+ADDI) when the constant does not fit 12 bits.
module rv32_instr_encoder
  import rv32_instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_fmt,
  input  logic [6:0]  req_opcode,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_pulse,
  output logic        err_sticky
);

  enc_state_t  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pend_q, pend_d;
  logic        err_pulse_q, err_pulse_d;
  logic        err_sticky_q, err_sticky_d;

  logic [31:0] imm_mask;
  logic        range_ok;
  logic [31:0] enc_word;
  logic        li_small;
  logic        li_lo_zero;
  logic [19:0] li_hi;
  logic [31:0] li_lui;
  logic [31:0] li_addi_x0;
  logic [31:0] li_addi_rd;
  logic        accept;
  logic        take;

  rv32_imm_pack u_imm_pack (
    .fmt_i      (req_fmt),
    .imm_i      (req_imm),
    .mask_o     (imm_mask),
    .range_ok_o (range_ok)
  );

  always_comb begin
    enc_word = '0;
    case (req_fmt)
      FMT_R:        enc_word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
      FMT_I:        enc_word = imm_mask | {12'b0, req_rs1, req_funct3, req_rd, req_opcode};
      FMT_S, FMT_B: enc_word = imm_mask | {7'b0, req_rs2, req_rs1, req_funct3, 5'b0, req_opcode};
      FMT_U, FMT_J: enc_word = imm_mask | {20'b0, req_rd, req_opcode};
      default:      enc_word = '0;
    endcase
  end

  // hi rounds up by imm[11] so that the sign-extended ADDI lo lands back on imm.
  always_comb begin
    li_small   = fits_signed(req_imm, 12);
    li_lo_zero = (req_imm[11:0] == 12'h000);
    li_hi      = req_imm[31:12] + {19'b0, req_imm[11]};
    li_lui     = {li_hi, req_rd, OPCODE_LUI};
    li_addi_x0 = {req_imm[11:0], 5'd0, FUNCT3_ADDI, req_rd, OPCODE_ARITH_I};
    li_addi_rd = {req_imm[11:0], req_rd, FUNCT3_ADDI, req_rd, OPCODE_ARITH_I};
  end

  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_EMIT) && out_ready);
  assign out_valid = (state_q != ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign take      = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    pend_d       = pend_q;
    addr_d       = take ? (addr_q + 32'd4) : addr_q;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;

    case (state_q)
      ST_EMIT_LUI: begin
        if (out_ready) begin
          instr_d = pend_q;
          pend_d  = '0;
          state_d = ST_EMIT;
        end
      end
      default: begin
        if (state_q == ST_EMIT && out_ready) begin
          state_d = ST_IDLE;
        end
        if (accept) begin
          if (!range_ok) begin
            state_d      = ST_IDLE;
            err_pulse_d  = 1'b1;
            err_sticky_d = 1'b1;
          end else if (req_fmt == FMT_LI) begin
            if (li_small) begin
              instr_d = li_addi_x0;
              state_d = ST_EMIT;
            end else if (li_lo_zero) begin
              instr_d = li_lui;
              state_d = ST_EMIT;
            end else begin
              instr_d = li_lui;
              pend_d  = li_addi_rd;
              state_d = ST_EMIT_LUI;
            end
          end else begin
            instr_d = enc_word;
            state_d = ST_EMIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      addr_q       <= BASE_ADDR;
      pend_q       <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
      pend_q       <= pend_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_instr  = instr_q;
  assign out_addr   = addr_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Scoreboard bench for rv32_instr_encoder: directed test-plan cases plus randomized
// requests checked against a field-level reference model.
module tb_rv32_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_fmt = '0;
  logic [6:0]  req_opcode = '0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [2:0]  req_funct3 = '0;
  logic [6:0]  req_funct7 = '0;
  logic [31:0] req_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_pulse;
  logic        err_sticky;

  rv32_instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt(req_fmt), .req_opcode(req_opcode),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [31:0] addr; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] exp_addr = BASE;
  int          exp_err  = 0;
  int          seen_err = 0;
  int          checks   = 0;
  int          errors   = 0;
  bit          rand_bp  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // Reference model: straight from the RV32I field layouts and the LI split rule.
  task automatic model(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm,
                       output bit rej, output int n, output logic [31:0] w0, output logic [31:0] w1);
    int signed   s;
    logic [31:0] hi;
    s = imm; rej = 1'b0; n = 1; w0 = '0; w1 = '0;
    case (fmt)
      3'd0: w0 = {f7, rs2, rs1, f3, rd, op};
      3'd1: begin rej = !(s >= -2048 && s <= 2047); w0 = {imm[11:0], rs1, f3, rd, op}; end
      3'd2: begin rej = !(s >= -2048 && s <= 2047); w0 = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; end
      3'd3: begin
        rej = !(s >= -4096 && s <= 4094 && imm[0] == 1'b0);
        w0 = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      3'd4: w0 = {imm[31:12], rd, op};
      3'd5: begin
        rej = !(s >= -(1 << 20) && s <= (1 << 20) - 2 && imm[0] == 1'b0);
        w0 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      3'd6: begin
        hi = (imm + 32'h800) >> 12;
        if (s >= -2048 && s <= 2047) w0 = {imm[11:0], 5'd0, 3'b000, rd, 7'h13};
        else if (imm[11:0] == 12'h000) w0 = {hi[19:0], rd, 7'h37};
        else begin
          n = 2;
          w0 = {hi[19:0], rd, 7'h37};
          w1 = {imm[11:0], rd, 3'b000, rd, 7'h13};
        end
      end
      default: rej = 1'b1;
    endcase
    if (rej) n = 0;
  endtask

  // Present a request (called at posedge+#1), wait for the handshake, record expectations.
  task automatic issue(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm,
                       input bit rej, input int n, input logic [31:0] w0, input logic [31:0] w1);
    int  waited;
    bit  done;
    exp_t e;
    req_fmt = fmt; req_opcode = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    req_funct3 = f3; req_funct7 = f7; req_imm = imm; req_valid = 1'b1;
    waited = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        done = 1'b1;
        if (rej) exp_err++;
        for (int i = 0; i < n; i++) begin
          e.instr = (i == 0) ? w0 : w1;
          e.addr  = exp_addr;
          exp_q.push_back(e);
          exp_addr = exp_addr + 32'd4;
        end
      end else begin
        @(posedge clk);
        waited++;
        if (waited > 200) begin
          checks++; errors++;
          $display("FAIL req_ready_timeout: waited %0d cycles expected accept", waited);
          done = 1'b1;
        end
      end
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic issue_model(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] imm);
    bit rej; int n; logic [31:0] w0, w1;
    model(fmt, op, rd, rs1, rs2, f3, f7, imm, rej, n, w0, w1);
    issue(fmt, op, rd, rs1, rs2, f3, f7, imm, rej, n, w0, w1);
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pop and compare every word the consumer takes.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && err_pulse) seen_err++;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got %08h at %08h expected none", out_instr, out_addr);
      end else begin
        e = exp_q.pop_front();
        check("out_instr", out_instr, e.instr);
        check("out_addr", out_addr, e.addr);
      end
    end
  end

  int bnd[14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4097,
                  1 << 20, -(1 << 20), (1 << 20) - 2, 0, 32'h1000, 32'h7FFFF000};

  initial begin
    logic [31:0] hold_instr;
    logic [31:0] lui_addr;
    logic [31:0] imm;
    int          waited;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_err_sticky", {31'b0, err_sticky}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 1, 32'h00500093, 32'h0);
    issue(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b0, 1, 32'h00208463, 32'h0);
    issue(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 1'b0, 1, 32'h001000EF, 32'h0);
    issue(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF, 1'b0, 2, 32'h123462B7, 32'hFFF28293);
    issue(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1000, 1'b0, 1, 32'h000012B7, 32'h0);
    issue(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b0, 1, 32'hFFF00293, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    // Rejects: one-cycle err_pulse, no output word.
    issue(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b1, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("rej_b_pulse", {31'b0, err_pulse}, 32'd1);
    check("rej_b_no_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("rej_b_pulse_end", {31'b0, err_pulse}, 32'd0);
    check("rej_b_sticky", {31'b0, err_sticky}, 32'd1);
    @(posedge clk); #1;
    issue(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("rej_i_pulse", {31'b0, err_pulse}, 32'd1);
    @(posedge clk); #1;
    issue(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 1'b1, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("rej_j_pulse", {31'b0, err_pulse}, 32'd1);
    check("rej_addr_held", out_addr, exp_addr);
    @(posedge clk); #1;

    // Backpressure on the LUI half of a two-word LI.
    out_ready = 1'b0;
    lui_addr = exp_addr;
    issue(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF, 1'b0, 2, 32'h123462B7, 32'hFFF28293);
    hold_instr = 32'h123462B7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_instr", out_instr, hold_instr);
      check("bp_addr", out_addr, lui_addr);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      issue_model(3'd1, 7'h13, 5'(i + 1), 5'(i), 5'd0, 3'd0, 7'd0, 32'(i * 3));

    // Reset while the LUI is held: pending ADDI must vanish.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(3'd6, 7'h00, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0ABCD123, 1'b0, 0, 32'h0, 32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_addr = BASE;
    @(negedge clk);
    check("rstmid_valid", {31'b0, out_valid}, 32'd0);
    check("rstmid_addr", out_addr, BASE);
    check("rstmid_sticky", {31'b0, err_sticky}, 32'd0);
    exp_err = 0; seen_err = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    issue(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 1, 32'h00500093, 32'h0);

    // Randomized requests under random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: imm = 32'($signed($urandom_range(0, 6000)) - 3000);
        1: imm = bnd[$urandom_range(0, 13)];
        2: imm = $urandom;
        3: imm = 32'($signed($urandom_range(0, 32'h20_0000)) - 32'sh10_0000);
        default: imm = {$urandom_range(0, 1) ? 20'hFFFFF : 20'h0, 12'($urandom)};
      endcase
      issue_model(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 3'($urandom), 7'($urandom), imm);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    #1;
    rand_bp = 1'b0;
    out_ready = 1'b1;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("err_pulse_count", 32'(seen_err), 32'(exp_err));
    check("err_sticky_end", {31'b0, err_sticky}, {31'b0, (exp_err != 0)});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
